// File: rtl/tns_enc_25_pkg.sv
// Shared TNS definitions: codeword length, binary width and the 25 weights
// in decoder bit order (code[0]=TNS01_C ... code[24]=TNS09_C).
package tns_enc_25_pkg;

  localparam int TNS_CW_LEN = 25;
  localparam int BLEN09_C   = 19;

  typedef logic [BLEN09_C-1:0]   tns_word_t;
  typedef logic [TNS_CW_LEN-1:0] tns_code_t;

  // Each weight is at most one more than the sum of all lower weights,
  // so greedy selection reaches every value up to the full sum.
  localparam tns_word_t TNS01_C = 19'd1;
  localparam tns_word_t TNS01_B = 19'd2;
  localparam tns_word_t TNS01_A = 19'd3;
  localparam tns_word_t TNS02_C = 19'd5;
  localparam tns_word_t TNS02_B = 19'd8;
  localparam tns_word_t TNS02_A = 19'd13;
  localparam tns_word_t TNS03_C = 19'd21;
  localparam tns_word_t TNS03_B = 19'd34;
  localparam tns_word_t TNS03_A = 19'd55;
  localparam tns_word_t TNS04_C = 19'd89;
  localparam tns_word_t TNS04_B = 19'd144;
  localparam tns_word_t TNS04_A = 19'd233;
  localparam tns_word_t TNS05_C = 19'd377;
  localparam tns_word_t TNS05_B = 19'd610;
  localparam tns_word_t TNS05_A = 19'd987;
  localparam tns_word_t TNS06_C = 19'd1597;
  localparam tns_word_t TNS06_B = 19'd2584;
  localparam tns_word_t TNS06_A = 19'd4181;
  localparam tns_word_t TNS07_C = 19'd6765;
  localparam tns_word_t TNS07_B = 19'd10946;
  localparam tns_word_t TNS07_A = 19'd17711;
  localparam tns_word_t TNS08_C = 19'd28657;
  localparam tns_word_t TNS08_B = 19'd46368;
  localparam tns_word_t TNS08_A = 19'd75025;
  localparam tns_word_t TNS09_C = 19'd121393;

  localparam tns_word_t TNS_MAX =
      TNS01_C + TNS01_B + TNS01_A + TNS02_C + TNS02_B + TNS02_A +
      TNS03_C + TNS03_B + TNS03_A + TNS04_C + TNS04_B + TNS04_A +
      TNS05_C + TNS05_B + TNS05_A + TNS06_C + TNS06_B + TNS06_A +
      TNS07_C + TNS07_B + TNS07_A + TNS08_C + TNS08_B + TNS08_A + TNS09_C;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } enc_state_t;

endpackage

// File: rtl/tns_weight_rom_25.sv
// Combinational weight lookup: codeword bit index -> TNS weight.
module tns_weight_rom_25
  import tns_enc_25_pkg::*;
(
  input  logic [4:0]          index,
  output logic [BLEN09_C-1:0] weight
);

  always_comb begin
    weight = '0;
    case (index)
      5'd0:  weight = TNS01_C;
      5'd1:  weight = TNS01_B;
      5'd2:  weight = TNS01_A;
      5'd3:  weight = TNS02_C;
      5'd4:  weight = TNS02_B;
      5'd5:  weight = TNS02_A;
      5'd6:  weight = TNS03_C;
      5'd7:  weight = TNS03_B;
      5'd8:  weight = TNS03_A;
      5'd9:  weight = TNS04_C;
      5'd10: weight = TNS04_B;
      5'd11: weight = TNS04_A;
      5'd12: weight = TNS05_C;
      5'd13: weight = TNS05_B;
      5'd14: weight = TNS05_A;
      5'd15: weight = TNS06_C;
      5'd16: weight = TNS06_B;
      5'd17: weight = TNS06_A;
      5'd18: weight = TNS07_C;
      5'd19: weight = TNS07_B;
      5'd20: weight = TNS07_A;
      5'd21: weight = TNS08_C;
      5'd22: weight = TNS08_B;
      5'd23: weight = TNS08_A;
      5'd24: weight = TNS09_C;
      default: weight = '0;
    endcase
  end

endmodule

// File: rtl/tns_enc_25.sv
// Iterative greedy TNS encoder: resolves STEPS_PER_CYCLE codeword bits per
// clock, MSB first, with valid/ready on both sides and registered outputs.
module tns_enc_25
  import tns_enc_25_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 1
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BLEN09_C-1:0]   datain,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TNS_CW_LEN-1:0] codeout,
  output logic                  err
);

  localparam logic [4:0] SPC      = 5'(STEPS_PER_CYCLE);
  localparam logic [4:0] LAST_IDX = 5'(STEPS_PER_CYCLE - 1);
  localparam logic [4:0] TOP_IDX  = 5'(TNS_CW_LEN - 1);

  enc_state_t state, state_nxt;
  tns_word_t  rem;
  tns_code_t  code;
  logic [4:0] idx;
  logic       accept, last_step, release_out;
  logic       in_ready_nxt, out_valid_nxt;

  tns_word_t rem_c  [STEPS_PER_CYCLE+1];
  tns_code_t code_c [STEPS_PER_CYCLE+1];

  assign accept      = (state == ST_IDLE) && in_valid && in_ready;
  assign last_step   = (state == ST_RUN) && (idx == LAST_IDX);
  assign release_out = (state == ST_DONE) && out_valid && out_ready;

  // Compare/subtract chain, highest weight of this cycle first.
  assign rem_c[0]  = rem;
  assign code_c[0] = code;
  for (genvar s = 0; s < STEPS_PER_CYCLE; s++) begin : g_step
    localparam logic [4:0] OFF = 5'(s);
    logic [4:0] bit_idx;
    tns_word_t  w;
    logic       take;
    assign bit_idx = idx - OFF;
    tns_weight_rom_25 u_rom (.index(bit_idx), .weight(w));
    assign take        = (rem_c[s] >= w);
    assign rem_c[s+1]  = take ? (rem_c[s] - w) : rem_c[s];
    assign code_c[s+1] = code_c[s] | (tns_code_t'(take) << bit_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept)      state_nxt = ST_RUN;
      ST_RUN:  if (last_step)   state_nxt = ST_DONE;
      ST_DONE: if (release_out) state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_nxt  = in_ready;
    out_valid_nxt = out_valid;
    unique case (state)
      ST_IDLE: begin
        in_ready_nxt  = !accept;
        out_valid_nxt = 1'b0;
      end
      ST_RUN: begin
        in_ready_nxt  = 1'b0;
        out_valid_nxt = last_step;
      end
      ST_DONE: begin
        if (release_out) begin
          in_ready_nxt  = 1'b1;
          out_valid_nxt = 1'b0;
        end
      end
      default: begin
        in_ready_nxt  = 1'b0;
        out_valid_nxt = 1'b0;
      end
    endcase
  end

  // accept -> RUN: load word; RUN -> DONE: publish code and leftover check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      codeout   <= '0;
      err       <= 1'b0;
      rem       <= '0;
      code      <= '0;
      idx       <= '0;
    end else begin
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      if (accept) begin
        rem  <= datain;
        code <= '0;
        idx  <= TOP_IDX;
      end else if (state == ST_RUN) begin
        rem  <= rem_c[STEPS_PER_CYCLE];
        code <= code_c[STEPS_PER_CYCLE];
        idx  <= last_step ? 5'd0 : (idx - SPC);
        if (last_step) begin
          codeout <= code_c[STEPS_PER_CYCLE];
          err     <= (rem_c[STEPS_PER_CYCLE] != '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_tns_enc_25.sv
// Bench for tns_enc_25: Fibonacci-weight greedy model, per-cycle monitor on
// the STEPS_PER_CYCLE=1 instance, plus round trips on 5- and 25-step instances.
module tb_tns_enc_25;

  localparam int N1   = 25;
  localparam int MAXV = 317809;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic        rst_n, aux_rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, err;
  logic [18:0] datain;
  logic [24:0] codeout;

  tns_enc_25 #(.STEPS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .datain(datain), .out_valid(out_valid), .out_ready(out_ready),
    .codeout(codeout), .err(err)
  );

  int unsigned wt [25];
  initial begin
    wt[0] = 1;
    wt[1] = 2;
    for (int i = 2; i < 25; i++) wt[i] = wt[i-1] + wt[i-2];
  end

  function automatic void model(input int unsigned x, output logic [24:0] c, output logic e);
    int unsigned r;
    r = x;
    c = '0;
    for (int i = 24; i >= 0; i--) begin
      if (r >= wt[i]) begin
        c[i] = 1'b1;
        r -= wt[i];
      end
    end
    e = (r != 0);
  endfunction

  function automatic int unsigned dec(input logic [24:0] c);
    int unsigned s;
    s = 0;
    for (int i = 0; i < 25; i++) if (c[i]) s += wt[i];
    return s;
  endfunction

  task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Per-cycle compare process for the single-step instance
  int unsigned accq[$];
  int          accc[$];
  bit          was_vld = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      accq.delete();
      accc.delete();
      was_vld = 1'b0;
      check("reset_outputs", !in_ready && !out_valid && codeout == 0 && !err,
            {in_ready, out_valid, err, codeout}, 0);
    end else begin
      if (out_valid) begin
        if (accq.size() == 0) begin
          check("spurious_out_valid", 1'b0, 1, 0);
        end else begin
          logic [24:0] ec;
          logic        ee;
          model(accq[0], ec, ee);
          check("mon_err", err == ee, err, ee);
          if (!ee) check("mon_code", codeout == ec && dec(codeout) == accq[0], codeout, ec);
          if (!was_vld) check("mon_latency", cyc == accc[0] + 1 + N1, cyc - accc[0], 1 + N1);
          if (out_ready) begin
            void'(accq.pop_front());
            void'(accc.pop_front());
          end
        end
        check("in_ready_while_busy", !in_ready, in_ready, 0);
      end
      if (in_valid && in_ready) begin
        accq.push_back(int'(datain));
        accc.push_back(cyc);
      end
      was_vld = out_valid;
    end
  end

  task automatic send(input int unsigned x, output int t);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      check("in_ready_timeout", 1'b0, 0, 1);
      t = -1;
      return;
    end
    in_valid = 1'b1;
    datain   = 19'(x);
    @(posedge clk); #1;
    t        = cyc;
    in_valid = 1'b0;
    datain   = 19'($urandom);
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    if (!out_valid) check("out_valid_timeout", 1'b0, 0, 1);
  endtask

  task automatic send_chk(input string name, input int unsigned x, input logic [24:0] ec, input logic ee);
    int t;
    send(x, t);
    wait_out();
    check({name, "_err"}, err === ee, err, ee);
    if (!ee) check({name, "_code"}, codeout === ec, codeout, ec);
    @(posedge clk); #1;
    check({name, "_release"}, in_ready && !out_valid, {in_ready, out_valid}, 2'b10);
  endtask

  // Round trips on the wider-step instances
  bit aux_done [2];
  for (genvar g = 0; g < 2; g++) begin : g_aux
    localparam int SPC = (g == 0) ? 5 : 25;
    localparam int NA  = 25 / SPC;
    logic        a_iv, a_ir, a_ov, a_or, a_err;
    logic [18:0] a_din;
    logic [24:0] a_code;

    tns_enc_25 #(.STEPS_PER_CYCLE(SPC)) u_enc (
      .clk(clk), .rst_n(aux_rst_n), .in_valid(a_iv), .in_ready(a_ir),
      .datain(a_din), .out_valid(a_ov), .out_ready(a_or),
      .codeout(a_code), .err(a_err)
    );

    initial begin
      logic [24:0] ec;
      logic        ee;
      int          n;
      int unsigned x;
      a_iv = 1'b0;
      a_din = '0;
      a_or = 1'b1;
      aux_done[g] = 1'b0;
      wait (aux_rst_n === 1'b1);
      @(posedge clk); #1;
      for (int i = 0; i < 400; i++) begin
        if (i < 200)       x = i;
        else if (i == 200) x = MAXV;
        else if (i == 201) x = MAXV + 1;
        else               x = $urandom_range(MAXV, 0);
        n = 0;
        while (!a_ir && n < 100) begin @(posedge clk); #1; n++; end
        a_iv  = 1'b1;
        a_din = 19'(x);
        @(posedge clk); #1;
        a_iv  = 1'b0;
        a_din = 19'($urandom);
        n = 0;
        while (!a_ov && n < 100) begin @(posedge clk); #1; n++; end
        model(x, ec, ee);
        check($sformatf("aux%0d_latency", SPC), n == NA, n, NA);
        check($sformatf("aux%0d_err", SPC), a_err == ee, a_err, ee);
        if (!ee) check($sformatf("aux%0d_code_%0d", SPC, x), a_code == ec && dec(a_code) == x, a_code, ec);
        @(posedge clk); #1;
      end
      aux_done[g] = 1'b1;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t1, t2, n;
    logic [24:0] held;
    rst_n = 1'b0;
    aux_rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    datain = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    aux_rst_n = 1'b1;
    check("in_ready_low_after_release", !in_ready, in_ready, 0);
    @(posedge clk); #1;
    check("in_ready_first_edge", in_ready, in_ready, 1);

    // Hand-computed codewords
    send_chk("zero",    0,      25'h0000000, 1'b0);
    send_chk("one",     1,      25'h0000001, 1'b0);
    send_chk("four",    4,      25'h0000005, 1'b0);
    send_chk("hundred", 100,    25'h0000214, 1'b0);
    send_chk("tns09c",  121393, 25'h1000000, 1'b0);
    send_chk("max",     MAXV,   25'h1FFFFFF, 1'b0);
    send_chk("max_p1",  MAXV + 1, 25'h0,     1'b1);

    // Initiation interval with out_ready held high
    send(777, t1);
    send(778, t2);
    check("initiation_interval", t2 - t1 == N1 + 2, t2 - t1, N1 + 2);
    wait_out();
    @(posedge clk); #1;

    // Backpressure: hold the result while a second word waits
    out_ready = 1'b0;
    send(1000, t1);
    wait_out();
    held = codeout;
    check("bp_code", held == 25'h0004020, held, 25'h0004020);
    in_valid = 1'b1;
    datain   = 19'd2000;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold_%0d", i), out_valid && !in_ready && codeout == held && !err,
            {out_valid, in_ready, err, codeout}, {3'b100, held});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_one_cycle", in_ready && !out_valid, {in_ready, out_valid}, 2'b10);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second_accepted", !in_ready, in_ready, 0);
    wait_out();
    @(posedge clk); #1;

    // Reset during RUN
    send(5000, t1);
    repeat (11) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("async_reset_now", !in_ready && !out_valid && codeout == 0 && !err,
          {in_ready, out_valid, err, codeout}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_release_ready_low", !in_ready, in_ready, 0);
    @(posedge clk); #1;
    check("rst_release_ready_high", in_ready, in_ready, 1);
    send_chk("after_reset", 5000, 25'h0022512, 1'b0);

    // Sweep: monitor checks every word
    for (int i = 0; i < 1024; i++) send(i, t1);
    for (int i = 0; i < 300; i++) send($urandom_range(MAXV, 0), t1);
    for (int i = 0; i < 20; i++) send($urandom_range(524287, MAXV + 1), t1);
    n = 0;
    while (accq.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    check("drain", accq.size() == 0, accq.size(), 0);

    n = 0;
    while (!(aux_done[0] && aux_done[1]) && n < 20000) begin @(posedge clk); #1; n++; end
    check("aux_complete", aux_done[0] && aux_done[1], {aux_done[0], aux_done[1]}, 2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
